// File: rtl/mem_responder.sv
// Single-port word memory answering byte/half/word accesses after a fixed
// number of wait cycles, with a one-cycle READY/ERR/RDATA response strobe.
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        REQ,
    input  logic        WE,
    input  logic [9:0]  ADDR,
    input  logic [1:0]  SIZE,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        READY,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH];

    logic        acc_we;
    logic [9:0]  acc_addr;
    logic [1:0]  acc_size;
    logic [31:0] acc_wdata;
    logic [7:0]  acc_idx;
    logic        acc_err;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] cur_word;
    logic [31:0] wmerge;
    logic [31:0] ld_data;
    logic        commit;
    logic        mem_wr;

    // Zero-wait accesses commit on the accept edge, so use the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = WE;
            acc_addr  = ADDR;
            acc_size  = SIZE;
            acc_wdata = WDATA;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_idx  = 8'(32'(acc_addr[9:2]) % DEPTH);
    assign cur_word = mem[acc_idx];

    always_comb begin
        acc_err = 1'b0;
        unique case (acc_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = acc_addr[0];
            2'b10:   acc_err = |acc_addr[1:0];
            default: acc_err = 1'b1;
        endcase
    end

    always_comb begin
        be    = 4'b0000;
        wlane = acc_wdata;
        unique case (acc_size)
            2'b00: begin
                be    = 4'b0001 << acc_addr[1:0];
                wlane = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{acc_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wmerge[8*k +: 8] = be[k] ? wlane[8*k +: 8] : cur_word[8*k +: 8];
        end
    end

    always_comb begin
        ld_data = '0;
        unique case (acc_size)
            2'b00: ld_data = {24'd0, cur_word[{acc_addr[1:0], 3'b000} +: 8]};
            2'b01: ld_data = {16'd0, acc_addr[1] ? cur_word[31:16]
                                                 : cur_word[15:0]};
            2'b10:   ld_data = cur_word;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    we_d    = WE;
                    addr_d  = ADDR;
                    size_d  = SIZE;
                    wdata_d = WDATA;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d = commit;
        err_d   = commit & acc_err;
        rdata_d = (commit && !acc_err && !acc_we) ? ld_data : 32'd0;
        busy_d  = (state_d != S_IDLE);
    end

    // An access aborted by reset must never reach storage.
    assign mem_wr = commit & acc_we & ~acc_err & RST_n;

    always_ff @(posedge CLK) begin
        if (mem_wr) begin
            mem[acc_idx] <= wmerge;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign RDATA = rdata_q;
    assign READY = ready_q;
    assign ERR   = err_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array model.
module tb_mem_responder;

    localparam int W = 2;

    typedef struct {
        int          t;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        REQ, WE;
    logic [9:0]  ADDR;
    logic [1:0]  SIZE;
    logic [31:0] WDATA, RDATA;
    logic        READY, ERR, BUSY;

    logic        req0, we0;
    logic [9:0]  addr0;
    logic [1:0]  size0;
    logic [31:0] wdata0, rdata0;
    logic        ready0, err0, busy0;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_from = -1;
    int   busy_to = -1;
    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] mem_m [256];

    mem_responder #(.WAIT_CYCLES(W), .DEPTH(256)) u_dut (
        .CLK(CLK), .RST_n(RST_n), .REQ(REQ), .WE(WE), .ADDR(ADDR),
        .SIZE(SIZE), .WDATA(WDATA), .RDATA(RDATA), .READY(READY),
        .ERR(ERR), .BUSY(BUSY)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut0 (
        .CLK(CLK), .RST_n(RST_n), .REQ(req0), .WE(we0), .ADDR(addr0),
        .SIZE(size0), .WDATA(wdata0), .RDATA(rdata0), .READY(ready0),
        .ERR(err0), .BUSY(busy0)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [9:0] a,
                                   input logic [1:0] sz,
                                   input logic [31:0] wd);
        exp_t        r;
        int          idx;
        int          sh;
        logic [31:0] mask;
        idx = int'(a) / 4;
        sh  = 8 * (int'(a) % 4);
        r.t = 0;
        r.d = 32'd0;
        r.e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && (int'(a) % 4) != 0);
        if (!r.e) begin
            if (sz == 2'd0) mask = 32'hFF << sh;
            else if (sz == 2'd1) mask = 32'hFFFF << sh;
            else mask = 32'hFFFF_FFFF;
            if (we) begin
                mem_m[idx] = (mem_m[idx] & ~mask) | ((wd << sh) & mask);
            end else begin
                r.d = (mem_m[idx] & mask) >> sh;
            end
        end
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the first idle negedge.
    task automatic issue(input logic we, input logic [9:0] a,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input bit fixed, input logic [31:0] xd,
                         input logic xe);
        exp_t r;
        REQ   = 1'b1;
        WE    = we;
        ADDR  = a;
        SIZE  = sz;
        WDATA = wd;
        r = model(we, a, sz, wd);
        if (fixed) begin
            r.d = xd;
            r.e = xe;
        end
        r.t = cyc + 1 + W;
        sbq.push_back(r);
        busy_from = cyc + 1;
        busy_to   = cyc + 1 + W;
        @(negedge CLK);
        while (cyc <= busy_to) begin
            REQ   = 1'($urandom);
            WE    = 1'($urandom);
            ADDR  = 10'($urandom);
            SIZE  = 2'($urandom);
            WDATA = $urandom;
            @(negedge CLK);
        end
        REQ = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST_n) begin
            chk("busy", 32'(BUSY), 32'(cyc >= busy_from && cyc <= busy_to));
            if (READY) begin
                if (sbq.size() == 0) begin
                    chk("spurious_ready", 32'(READY), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rdata", RDATA, mon_e.d);
                    chk("err", 32'(ERR), 32'(mon_e.e));
                    chk("latency", 32'(cyc), 32'(mon_e.t));
                end
            end else begin
                chk("idle_rdata", RDATA, 32'd0);
                chk("idle_err", 32'(ERR), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0;
        REQ = 1'b0; WE = 1'b0; ADDR = '0; SIZE = '0; WDATA = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = '0; wdata0 = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);

        RST_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(1'b1, 10'(i * 4), 2'd2, $urandom, 1'b0, 32'd0, 1'b0);
        end

        issue(1'b1, 10'h010, 2'd2, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 10'h010, 2'd2, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 10'h012, 2'd0, 32'hABCD0055, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 10'h010, 2'd2, 32'd0, 1'b1, 32'hDE55BEEF, 1'b0);
        issue(1'b0, 10'h013, 2'd0, 32'd0, 1'b1, 32'h000000DE, 1'b0);
        issue(1'b0, 10'h011, 2'd1, 32'd0, 1'b1, 32'd0, 1'b1);
        issue(1'b0, 10'h010, 2'd3, 32'd0, 1'b1, 32'd0, 1'b1);
        issue(1'b1, 10'h011, 2'd2, 32'h0BADF00D, 1'b1, 32'd0, 1'b1);
        issue(1'b0, 10'h010, 2'd2, 32'd0, 1'b1, 32'hDE55BEEF, 1'b0);
        issue(1'b1, 10'h012, 2'd1, 32'h99991234, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 10'h010, 2'd2, 32'd0, 1'b1, 32'h1234BEEF, 1'b0);
        issue(1'b0, 10'h012, 2'd1, 32'd0, 1'b1, 32'h00001234, 1'b0);
        issue(1'b1, 10'h020, 2'd2, 32'hCAFEF00D, 1'b1, 32'd0, 1'b0);

        REQ = 1'b1; WE = 1'b1; ADDR = 10'h020; SIZE = 2'd2;
        WDATA = 32'h12345678;
        busy_from = cyc + 1;
        busy_to   = cyc + 1 + W;
        @(negedge CLK);
        REQ = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        chk("abort_ready", 32'(READY), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_err", 32'(ERR), 32'd0);
        chk("abort_rdata", RDATA, 32'd0);
        busy_from = -1;
        busy_to   = -1;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        issue(1'b0, 10'h020, 2'd2, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0);

        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), 10'($urandom), 2'($urandom), $urandom,
                  1'b0, 32'd0, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h040; size0 = 2'd2;
        wdata0 = 32'hA5C30F96;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i % 2 == 0) begin
                chk("w0_ready", 32'(ready0), 32'd1);
                chk("w0_busy", 32'(busy0), 32'd1);
                chk("w0_err", 32'(err0), 32'd0);
                chk("w0_rdata", rdata0, (i == 0) ? 32'd0 : 32'hA5C30F96);
                we0 = 1'b0;
            end else begin
                chk("w0_ready_gap", 32'(ready0), 32'd0);
                chk("w0_busy_gap", 32'(busy0), 32'd0);
                chk("w0_rdata_gap", rdata0, 32'd0);
            end
        end
        req0 = 1'b0;

        repeat (6) @(negedge CLK);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
